// File: rtl/mlu_operand_feeder.sv
// MLU Multiplier-layer operand feeder: expands one command into a stream of hot/cold
// operand vector pairs read from HotBuf/ColdBuf, buffered in a 2-entry output FIFO.
module mlu_operand_feeder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LANES  = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_hot_base,
  input  logic [ADDR_W-1:0] cmd_cold_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [LEN_W-1:0]  cmd_reuse,
  input  logic              cmd_sel,
  output logic              hot_rd_en,
  output logic [ADDR_W-1:0] hot_rd_addr,
  input  logic [WIDTH-1:0]  hot_rd_data [LANES],
  output logic              cold_rd_en,
  output logic [ADDR_W-1:0] cold_rd_addr,
  input  logic [WIDTH-1:0]  cold_rd_data [LANES],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  hot_out [LANES],
  output logic [WIDTH-1:0]  cold_out [LANES],
  output logic              sel_out,
  output logic              out_last,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e state_q, state_d;
  logic   alive_q;
  logic   done_q;

  logic [ADDR_W-1:0] hot_base_q, cold_base_q, hot_idx_q;
  logic [LEN_W-1:0]  len_q, reuse_q, beat_idx_q, grp_idx_q;
  logic              sel_q;

  logic ret_valid_q, ret_hot_q, ret_last_q;
  logic [WIDTH-1:0] hot_hold_q [LANES];

  logic [WIDTH-1:0] fifo_hot_q  [2][LANES];
  logic [WIDTH-1:0] fifo_cold_q [2][LANES];
  logic [1:0]       fifo_sel_q, fifo_last_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;

  logic             accept, issue, last_issue, credit, push, pop;
  logic [2:0]       occ;
  logic [WIDTH-1:0] push_hot  [LANES];
  logic [WIDTH-1:0] push_cold [LANES];

  // alive_q keeps cmd_ready low while reset is asserted even though the FSM sits in StIdle
  assign cmd_ready = alive_q && (state_q == StIdle);
  assign accept    = cmd_valid && cmd_ready;
  assign done      = done_q;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = ret_valid_q;

  // Credit counts FIFO entries plus the read in flight, less the beat leaving this cycle
  assign occ        = {1'b0, count_q} + {2'b00, ret_valid_q} - {2'b00, pop};
  assign credit     = (occ < 3'd2);
  assign issue      = (state_q == StRun) && credit;
  assign last_issue = issue && (beat_idx_q == len_q - LEN_W'(1));

  assign cold_rd_en   = issue && !sel_q;
  assign hot_rd_en    = cold_rd_en && (grp_idx_q == '0);
  assign cold_rd_addr = cold_base_q + ADDR_W'(beat_idx_q);
  assign hot_rd_addr  = hot_base_q + hot_idx_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (cmd_len == '0) ? StFin : StRun;
      end
      StRun: begin
        if (last_issue) state_d = StDrain;
      end
      StDrain: begin
        if ((count_q == 2'd0) && !ret_valid_q) state_d = StFin;
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      alive_q     <= 1'b0;
      done_q      <= 1'b0;
      hot_base_q  <= '0;
      cold_base_q <= '0;
      len_q       <= '0;
      reuse_q     <= LEN_W'(1);
      sel_q       <= 1'b0;
      beat_idx_q  <= '0;
      grp_idx_q   <= '0;
      hot_idx_q   <= '0;
      ret_valid_q <= 1'b0;
      ret_hot_q   <= 1'b0;
      ret_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      alive_q     <= 1'b1;
      done_q      <= (state_q == StFin);
      ret_valid_q <= issue;
      ret_hot_q   <= hot_rd_en;
      ret_last_q  <= last_issue;
      if (accept) begin
        hot_base_q  <= cmd_hot_base;
        cold_base_q <= cmd_cold_base;
        len_q       <= cmd_len;
        reuse_q     <= (cmd_reuse == '0) ? LEN_W'(1) : cmd_reuse;
        sel_q       <= cmd_sel;
        beat_idx_q  <= '0;
        grp_idx_q   <= '0;
        hot_idx_q   <= '0;
      end else if (issue) begin
        beat_idx_q <= beat_idx_q + LEN_W'(1);
        if (grp_idx_q == reuse_q - LEN_W'(1)) begin
          grp_idx_q <= '0;
          hot_idx_q <= hot_idx_q + ADDR_W'(1);
        end else begin
          grp_idx_q <= grp_idx_q + LEN_W'(1);
        end
      end
    end
  end

  // Pre_data beats carry zero operands; buffer beats reuse hot_hold between hot reads
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      push_hot[i]  = '0;
      push_cold[i] = '0;
      if (!sel_q) begin
        push_hot[i]  = ret_hot_q ? hot_rd_data[i] : hot_hold_q[i];
        push_cold[i] = cold_rd_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) hot_hold_q[i] <= '0;
    end else if (ret_valid_q && ret_hot_q) begin
      for (int i = 0; i < LANES; i++) hot_hold_q[i] <= hot_rd_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < 2; e++) begin
        for (int i = 0; i < LANES; i++) begin
          fifo_hot_q[e][i]  <= '0;
          fifo_cold_q[e][i] <= '0;
        end
      end
      fifo_sel_q  <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (push) begin
        for (int i = 0; i < LANES; i++) begin
          fifo_hot_q[wr_ptr_q][i]  <= push_hot[i];
          fifo_cold_q[wr_ptr_q][i] <= push_cold[i];
        end
        fifo_sel_q[wr_ptr_q]  <= sel_q;
        fifo_last_q[wr_ptr_q] <= ret_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      hot_out[i]  = fifo_hot_q[rd_ptr_q][i];
      cold_out[i] = fifo_cold_q[rd_ptr_q][i];
    end
    sel_out  = fifo_sel_q[rd_ptr_q];
    out_last = fifo_last_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_mlu_operand_feeder.sv
// Self-checking bench for mlu_operand_feeder: table of commands, SRAM models and a
// scoreboard of expected operand beats built from the buffer contents.
module tb_mlu_operand_feeder;

  localparam int WIDTH  = 16;
  localparam int LANES  = 16;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 12;
  localparam int NVEC   = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_hot_base, cmd_cold_base;
  logic [LEN_W-1:0]  cmd_len, cmd_reuse;
  logic              cmd_sel;
  logic              hot_rd_en, cold_rd_en;
  logic [ADDR_W-1:0] hot_rd_addr, cold_rd_addr;
  logic [WIDTH-1:0]  hot_rd_data  [LANES];
  logic [WIDTH-1:0]  cold_rd_data [LANES];
  logic              out_valid, out_ready;
  logic [WIDTH-1:0]  hot_out  [LANES];
  logic [WIDTH-1:0]  cold_out [LANES];
  logic              sel_out, out_last, done;

  typedef struct {
    logic [ADDR_W-1:0] hot_base;
    logic [ADDR_W-1:0] cold_base;
    int                len;
    int                reuse;
    logic              sel;
    logic [3:0]        rdy;
    int                exp_hot_rd;
    int                exp_cold_rd;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] hot_addr;
    logic [ADDR_W-1:0] cold_addr;
    logic              sel;
    logic              last;
  } exp_t;

  vec_t  vecs  [NVEC];
  string names [NVEC];
  exp_t  sb [$];
  int    n_checks = 0;
  int    n_pass   = 0;

  mlu_operand_feeder #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_hot_base (cmd_hot_base),
    .cmd_cold_base(cmd_cold_base),
    .cmd_len      (cmd_len),
    .cmd_reuse    (cmd_reuse),
    .cmd_sel      (cmd_sel),
    .hot_rd_en    (hot_rd_en),
    .hot_rd_addr  (hot_rd_addr),
    .hot_rd_data  (hot_rd_data),
    .cold_rd_en   (cold_rd_en),
    .cold_rd_addr (cold_rd_addr),
    .cold_rd_data (cold_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .hot_out      (hot_out),
    .cold_out     (cold_out),
    .sel_out      (sel_out),
    .out_last     (out_last),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] hot_word(input logic [ADDR_W-1:0] a, input int i);
    return 16'h4000 + 16'(int'(a) * 16 + i);
  endfunction

  function automatic logic [WIDTH-1:0] cold_word(input logic [ADDR_W-1:0] a, input int i);
    return 16'h8000 + 16'(int'(a) * 16 + i);
  endfunction

  // 1-cycle-latency buffer models
  always @(posedge clk) begin
    if (hot_rd_en)  for (int i = 0; i < LANES; i++) hot_rd_data[i]  <= hot_word(hot_rd_addr, i);
    if (cold_rd_en) for (int i = 0; i < LANES; i++) cold_rd_data[i] <= cold_word(cold_rd_addr, i);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_beat(input string name, input int b);
    exp_t e;
    logic ok;
    logic [WIDTH-1:0] eh, ec;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s beat %0d: unexpected beat, none expected", name, b);
      return;
    end
    e  = sb.pop_front();
    ok = (sel_out == e.sel) && (out_last == e.last);
    for (int i = 0; i < LANES; i++) begin
      eh = e.sel ? '0 : hot_word(e.hot_addr, i);
      ec = e.sel ? '0 : cold_word(e.cold_addr, i);
      if (hot_out[i] !== eh || cold_out[i] !== ec) ok = 1'b0;
    end
    if (ok) n_pass++;
    else $display("FAIL %s beat %0d: got hot0=%h cold0=%h sel=%b last=%b expected hot0=%h cold0=%h sel=%b last=%b",
                  name, b, hot_out[0], cold_out[0], sel_out, out_last,
                  e.sel ? 16'h0 : hot_word(e.hot_addr, 0), e.sel ? 16'h0 : cold_word(e.cold_addr, 0),
                  e.sel, e.last);
  endtask

  task automatic run_cmd(input vec_t v, input string name);
    int   cyc, acc_cyc, done_cyc, done_cnt, done_lat, beats, hot_rd, cold_rd;
    int   addr_err, grp_err, hold_err, issued, popped, outst, outst_max, ov_seen, reuse_eff;
    logic accepted, stalled, prev_sel, prev_last;
    logic [WIDTH-1:0] prev_h0, prev_h15, prev_c0, prev_c15;
    exp_t e;
    reuse_eff = (v.reuse == 0) ? 1 : v.reuse;
    for (int b = 0; b < v.len; b++) begin
      e.hot_addr  = ADDR_W'((int'(v.hot_base) + b / reuse_eff) % 1024);
      e.cold_addr = ADDR_W'((int'(v.cold_base) + b) % 1024);
      e.sel       = v.sel;
      e.last      = (b == v.len - 1);
      sb.push_back(e);
    end
    cyc = 0; acc_cyc = 0; done_cyc = -100; done_cnt = 0; done_lat = -1; beats = 0;
    hot_rd = 0; cold_rd = 0; addr_err = 0; grp_err = 0; hold_err = 0;
    issued = 0; popped = 0; outst_max = 0; ov_seen = 0;
    accepted = 1'b0; stalled = 1'b0;
    prev_sel = 1'b0; prev_last = 1'b0; prev_h0 = '0; prev_h15 = '0; prev_c0 = '0; prev_c15 = '0;
    @(posedge clk); #1;
    cmd_valid     = 1'b1;
    cmd_hot_base  = v.hot_base;
    cmd_cold_base = v.cold_base;
    cmd_len       = LEN_W'(v.len);
    cmd_reuse     = LEN_W'(v.reuse);
    cmd_sel       = v.sel;
    out_ready     = v.rdy[0];
    while (cyc < 300 && !(done_cnt > 0 && cyc > done_cyc + 3)) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        accepted = 1'b1;
        acc_cyc  = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_lat = cyc - acc_cyc;
      end
      if (out_valid) ov_seen++;
      if (stalled && (!out_valid || hot_out[0] !== prev_h0 || hot_out[LANES-1] !== prev_h15 ||
                      cold_out[0] !== prev_c0 || cold_out[LANES-1] !== prev_c15 ||
                      sel_out !== prev_sel || out_last !== prev_last)) hold_err++;
      stalled  = out_valid && !out_ready;
      prev_h0  = hot_out[0];  prev_h15 = hot_out[LANES-1];
      prev_c0  = cold_out[0]; prev_c15 = cold_out[LANES-1];
      prev_sel = sel_out;     prev_last = out_last;
      outst = issued - popped;
      if (outst > outst_max) outst_max = outst;
      if (cold_rd_en) begin
        if (cold_rd_addr !== ADDR_W'((int'(v.cold_base) + cold_rd) % 1024)) addr_err++;
        if (hot_rd_en !== ((cold_rd % reuse_eff) == 0)) grp_err++;
        cold_rd++;
        issued++;
      end
      if (hot_rd_en) begin
        if (hot_rd_addr !== ADDR_W'((int'(v.hot_base) + hot_rd) % 1024)) addr_err++;
        hot_rd++;
      end
      if (out_valid && out_ready) begin
        check_beat(name, beats);
        beats++;
        popped++;
      end
      @(posedge clk); #1;
      if (accepted) cmd_valid = 1'b0;
      cyc++;
      out_ready = v.rdy[cyc % 4];
    end
    cmd_valid = 1'b0;
    check({name, " done_count"}, done_cnt, 1);
    check({name, " beats"}, beats, v.len);
    check({name, " leftover"}, sb.size(), 0);
    check({name, " hot_reads"}, hot_rd, v.exp_hot_rd);
    check({name, " cold_reads"}, cold_rd, v.exp_cold_rd);
    check({name, " addr_errors"}, addr_err, 0);
    check({name, " group_errors"}, grp_err, 0);
    check({name, " hold_errors"}, hold_err, 0);
    check({name, " outstanding_le_2"}, int'(outst_max <= 2), 1);
    if (v.len == 0) begin
      check({name, " done_latency"}, done_lat, 2);
      check({name, " no_out_valid"}, ov_seen, 0);
    end
    sb.delete();
  endtask

  initial begin
    vecs[0] = '{10'h000, 10'h010, 4, 4, 1'b0, 4'b1111, 1, 4}; names[0] = "basic";
    vecs[1] = '{10'h000, 10'h040, 6, 2, 1'b0, 4'b1111, 3, 6}; names[1] = "reuse2";
    vecs[2] = '{10'h005, 10'h080, 8, 3, 1'b0, 4'b1001, 3, 8}; names[2] = "backpressure";
    vecs[3] = '{10'h000, 10'h000, 3, 1, 1'b1, 4'b1111, 0, 0}; names[3] = "predata";
    vecs[4] = '{10'h000, 10'h000, 0, 1, 1'b0, 4'b1111, 0, 0}; names[4] = "len0";
    vecs[5] = '{10'h007, 10'h100, 2, 0, 1'b0, 4'b1111, 2, 2}; names[5] = "reuse0";
    vecs[6] = '{10'h3FF, 10'h3FE, 4, 1, 1'b0, 4'b1011, 4, 4}; names[6] = "wrap";

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_hot_base = '0; cmd_cold_base = '0;
    cmd_len = '0; cmd_reuse = '0; cmd_sel = 1'b0; out_ready = 1'b0;
    #22;
    check("rst cmd_ready", int'(cmd_ready), 0);
    check("rst rd_en", int'({hot_rd_en, cold_rd_en}), 0);
    check("rst addrs", int'({hot_rd_addr, cold_rd_addr}), 0);
    check("rst out_valid", int'(out_valid), 0);
    check("rst outputs", int'({hot_out[0], cold_out[LANES-1], sel_out, out_last, done}), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post-rst cmd_ready", int'(cmd_ready), 1);

    for (int k = 0; k < NVEC; k++) run_cmd(vecs[k], names[k]);

    // Abort a stalled command with an asynchronous reset mid-cycle
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_hot_base = 10'h020; cmd_cold_base = 10'h030;
    cmd_len = 12'd8; cmd_reuse = 12'd2; cmd_sel = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("abort pre out_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", int'(out_valid), 0);
    check("abort cmd_ready", int'(cmd_ready), 0);
    check("abort rd_en", int'({hot_rd_en, cold_rd_en}), 0);
    check("abort addrs", int'({hot_rd_addr, cold_rd_addr}), 0);
    check("abort outputs", int'({hot_out[0], cold_out[0], sel_out, out_last, done}), 0);
    begin
      int dn, ov;
      dn = 0; ov = 0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done) dn++;
        if (out_valid) ov++;
      end
      check("abort no_done", dn, 0);
      check("abort no_out_valid", ov, 0);
    end
    check("abort recovered cmd_ready", int'(cmd_ready), 1);
    run_cmd(vecs[1], "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
